// File: rtl/rr_mux4_arbiter_if.sv
// ---------------------------------------------------------------------------
// rr_mux4_arbiter_if
// Bundles the request/data/grant signals of the four-way round-robin mux
// arbiter.
//   req      : level request per requester (bit i = requester i)
//   din      : packed requester data, requester i at din[i*DW +: DW]
//   gnt      : one-hot grant, all-zero when idle
//   sel      : mux select (index of the granted requester)
//   dout     : data of the granted requester, 0 when nothing is granted
//   dout_vld : high while a grant is held
//   busy     : copy of dout_vld for sequencing logic
// The master modport is the requester side. The slave modport is the arbiter.
// ---------------------------------------------------------------------------
interface rr_mux4_arbiter_if #(
    parameter int DW = 1
);
    logic [3:0]      req;
    logic [4*DW-1:0] din;
    logic [3:0]      gnt;
    logic [1:0]      sel;
    logic [DW-1:0]   dout;
    logic            dout_vld;
    logic            busy;

    modport master (
        output req, din,
        input  gnt, sel, dout, dout_vld, busy
    );

    modport slave (
        input  req, din,
        output gnt, sel, dout, dout_vld, busy
    );
endinterface

// File: rtl/rr_mux4_arbiter.sv
// ---------------------------------------------------------------------------
// rr_mux4_arbiter
// Shares one 4:1 datapath mux between four level-requesting clients.
// Arbitration is round-robin. The search starts at the requester after the
// last one granted. A single grant is held for at most MAX_HOLD consecutive
// cycles while other requesters are waiting.
// Ports:
//   clk   : clock; all state changes on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : slave side of rr_mux4_arbiter_if (req/din in; gnt/sel/dout/
//           dout_vld/busy out)
// ---------------------------------------------------------------------------
module rr_mux4_arbiter #(
    parameter int DW       = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    rr_mux4_arbiter_if.slave   bus
);

    // hold counter is at least one bit wide, even when MAX_HOLD is 1
    localparam int HCW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     sel_q,   sel_d;
    logic [1:0]     ptr_q,   ptr_d;
    logic [HCW-1:0] hold_q,  hold_d;
    logic [3:0]     gnt_q,   gnt_d;
    logic           vld_q,   vld_d;

    logic           grant_new;
    logic [1:0]     new_sel;
    logic [3:0]     others;

    // Returns the first set bit of mask, searching from start upward (mod 4).
    // The 2-bit index wraps naturally.
    function automatic logic [1:0] pick(input logic [3:0] mask,
                                        input logic [1:0] start);
        logic [1:0] idx;
        logic [1:0] result;
        logic       found;
        result = start;
        found  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = start + 2'(k);
            if (!found && mask[idx]) begin
                result = idx;
                found  = 1'b1;
            end
        end
        return result;
    endfunction

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
        state_d   = state_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        grant_new = 1'b0;
        new_sel   = sel_q;
        others    = bus.req & ~(4'b0001 << sel_q);

        unique case (state_q)
            IDLE: begin
                if (bus.req != 4'b0000) begin
                    grant_new = 1'b1;
                    new_sel   = pick(bus.req, ptr_q);
                end
            end
            GRANT: begin
                if (!bus.req[sel_q]) begin
                    // Release. Re-arbitrate on the same edge so no idle cycle appears.
                    if (bus.req != 4'b0000) begin
                        grant_new = 1'b1;
                        new_sel   = pick(bus.req, ptr_q);
                    end else begin
                        state_d = IDLE;
                    end
                end else if (hold_q == HOLD_LAST) begin
                    // Expiry. Move to a waiting requester, or re-grant the
                    // current one if nobody else is asking.
                    grant_new = 1'b1;
                    new_sel   = (others != 4'b0000) ? pick(others, ptr_q) : sel_q;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (grant_new) begin
            state_d = GRANT;
            sel_d   = new_sel;
            hold_d  = '0;
            ptr_d   = new_sel + 2'd1;
        end

        vld_d = (state_d == GRANT);
        gnt_d = vld_d ? (4'b0001 << sel_d) : 4'b0000;
    end

    // NOTE: sequential state uses non-blocking assignments only; the reset branch is checked first so it overrides everything else.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            gnt_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            vld_q   <= vld_d;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.sel      = sel_q;
    assign bus.dout_vld = vld_q;
    assign bus.busy     = vld_q;
    // dout stays at 0 while idle, even though sel keeps its last value
    assign bus.dout     = vld_q ? bus.din[sel_q*DW +: DW] : '0;

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_mux4_arbiter
// Drives two arbiters with the same stimulus: one with MAX_HOLD=8 and one
// with MAX_HOLD=1. Both use DW=1. Every output is compared each cycle with a
// behavioural model. The model tracks the current owner and the number of
// cycles that owner has held the grant.
// ---------------------------------------------------------------------------
module tb_rr_mux4_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] din;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    rr_mux4_arbiter_if #(.DW(1)) if8 ();
    rr_mux4_arbiter_if #(.DW(1)) if1 ();

    assign if8.req = req;
    assign if8.din = din;
    assign if1.req = req;
    assign if1.din = din;

    rr_mux4_arbiter #(.DW(1), .MAX_HOLD(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if8)
    );

    rr_mux4_arbiter #(.DW(1), .MAX_HOLD(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    // Reference model state. Index 0 is MAX_HOLD=8 and index 1 is MAX_HOLD=1.
    // owner is -1 when idle. tenure counts the cycles the owner has held the grant.
    int m_limit [2] = '{8, 1};
    int m_owner [2];
    int m_sel   [2];
    int m_ptr   [2];
    int m_ten   [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic int rr_pick(input int mask, input int start);
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (start + k) % 4;
            if (((mask >> idx) & 1) != 0) return idx;
        end
        return -1;
    endfunction

    task automatic model_grant(input int m, input int who);
        m_owner[m] = who;
        m_sel[m]   = who;
        m_ptr[m]   = (who + 1) % 4;
        m_ten[m]   = 1;
    endtask

    task automatic model_step(input int m, input logic rst_v, input logic [3:0] r);
        int ri;
        int others;
        ri = int'(r);
        if (!rst_v) begin
            m_owner[m] = -1;
            m_sel[m]   = 0;
            m_ptr[m]   = 0;
            m_ten[m]   = 0;
        end else if (m_owner[m] < 0) begin
            if (ri != 0) model_grant(m, rr_pick(ri, m_ptr[m]));
        end else if (((ri >> m_owner[m]) & 1) == 0) begin
            if (ri != 0) model_grant(m, rr_pick(ri, m_ptr[m]));
            else         m_owner[m] = -1;
        end else if (m_ten[m] >= m_limit[m]) begin
            others = ri & ~(1 << m_owner[m]);
            if (others != 0) model_grant(m, rr_pick(others, m_ptr[m]));
            else             model_grant(m, m_owner[m]);
        end else begin
            m_ten[m]++;
        end
    endtask

    task automatic check_all();
        for (int m = 0; m < 2; m++) begin
            logic [3:0] e_gnt;
            logic       e_vld;
            logic       e_dout;
            logic [3:0] o_gnt;
            logic [1:0] o_sel;
            logic       o_dout, o_vld, o_busy;
            e_vld  = (m_owner[m] >= 0);
            e_gnt  = e_vld ? 4'(1 << m_owner[m]) : 4'b0000;
            e_dout = e_vld ? din[m_owner[m]] : 1'b0;
            o_gnt  = (m == 0) ? if8.gnt      : if1.gnt;
            o_sel  = (m == 0) ? if8.sel      : if1.sel;
            o_dout = (m == 0) ? if8.dout     : if1.dout;
            o_vld  = (m == 0) ? if8.dout_vld : if1.dout_vld;
            o_busy = (m == 0) ? if8.busy     : if1.busy;
            check($sformatf("gnt[h%0d]",  m_limit[m]), 32'(o_gnt),  32'(e_gnt));
            check($sformatf("sel[h%0d]",  m_limit[m]), 32'(o_sel),  32'(m_sel[m]));
            check($sformatf("dout[h%0d]", m_limit[m]), 32'(o_dout), 32'(e_dout));
            check($sformatf("vld[h%0d]",  m_limit[m]), 32'(o_vld),  32'(e_vld));
            check($sformatf("busy[h%0d]", m_limit[m]), 32'(o_busy), 32'(e_vld));
        end
    endtask

    // Apply one cycle of inputs, advance the model on the edge, then check.
    task automatic step(input logic rst_v, input logic [3:0] req_v, input logic [3:0] din_v);
        rst_n = rst_v;
        req   = req_v;
        din   = din_v;
        @(posedge clk);
        model_step(0, rst_v, req_v);
        model_step(1, rst_v, req_v);
        #1;
        check_all();
    endtask

    initial begin
        logic [3:0] r;
        rst_n = 1'b0;
        req   = 4'b0000;
        din   = 4'b0000;
        for (int m = 0; m < 2; m++) begin
            m_owner[m] = -1; m_sel[m] = 0; m_ptr[m] = 0; m_ten[m] = 0;
        end

        // Reset while every requester is asking.
        step(1'b0, 4'b1111, 4'b1111);
        step(1'b0, 4'b1111, 4'b1111);
        check("rst_gnt",  32'(if8.gnt),      32'h0);
        check("rst_sel",  32'(if8.sel),      32'h0);
        check("rst_vld",  32'(if8.dout_vld), 32'h0);
        check("rst_dout", 32'(if8.dout),     32'h0);
        step(1'b1, 4'b1111, 4'b1111);
        check("post_rst_gnt", 32'(if8.gnt), 32'h1);
        check("post_rst_sel", 32'(if8.sel), 32'h0);

        // A single requester holds the grant for 3 cycles, then releases it.
        step(1'b0, 4'b0000, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 4'b0100, 4'b0100);
            check("single_gnt",  32'(if8.gnt),  32'h4);
            check("single_dout", 32'(if8.dout), 32'h1);
        end
        step(1'b1, 4'b0000, 4'b0100);
        check("single_idle_vld", 32'(if8.dout_vld), 32'h0);
        check("single_idle_sel", 32'(if8.sel),      32'h2);

        // Round-robin: each owner drops its request after one cycle.
        step(1'b0, 4'b0000, 4'b0000);
        step(1'b1, 4'b1111, 4'b0101);
        check("rr_order", 32'(if8.gnt), 32'h1);
        for (int k = 1; k <= 4; k++) begin
            r = 4'b1111 & ~(4'b0001 << m_owner[0]);
            step(1'b1, r, 4'($urandom_range(0, 15)));
            check("rr_order", 32'(if8.gnt), 32'(1 << (k % 4)));
        end

        // Hold expiry with two requesters that keep asking.
        step(1'b0, 4'b0000, 4'b0000);
        for (int i = 1; i <= 24; i++) begin
            step(1'b1, 4'b0011, 4'($urandom_range(0, 15)));
            check("hold_rot", 32'(if8.gnt), (i <= 8) ? 32'h1 : (i <= 16) ? 32'h2 : 32'h1);
        end
        // A lone requester is re-granted when its hold expires.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 4'b0001, 4'b0001);
            check("hold_solo", 32'(if8.gnt), 32'h1);
        end

        // Reset in the middle of a grant (req1 with hold_cnt = 4).
        step(1'b0, 4'b0000, 4'b0000);
        for (int i = 0; i < 5; i++) step(1'b1, 4'b0010, 4'b0010);
        step(1'b0, 4'b0110, 4'b0110);
        check("midrst_gnt", 32'(if8.gnt), 32'h0);
        step(1'b1, 4'b0110, 4'b0110);
        check("midrst_first", 32'(if8.gnt), 32'h2);

        // With MAX_HOLD=1 the grant rotates every cycle.
        step(1'b0, 4'b0000, 4'b0000);
        for (int i = 1; i <= 6; i++) begin
            step(1'b1, 4'b1010, 4'b1010);
            check("h1_alt", 32'(if1.gnt), (i % 2 == 1) ? 32'h2 : 32'h8);
        end

        // Random traffic. Requests are sticky, with occasional resets.
        r = 4'b0000;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0) r = 4'($urandom_range(0, 15));
            step(($urandom_range(0, 49) != 0), r, 4'($urandom_range(0, 15)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
